// File: rtl/regfile_dump_reader_if.sv
// Beat stream carrying (register index, register value) pairs from the dump reader
// to the debug/trace consumer. Transfer happens when valid && ready.
interface regfile_dump_reader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range through one register-file read port and streams
// (addr, data) beats out, keeping a running XOR checksum of the dumped words.
module regfile_dump_reader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_addr_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  regfile_dump_reader_if.master out_if,
  output logic [DATA_W-1:0] checksum_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              error_q, error_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      end_q      <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      checksum_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      end_q      <= end_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      checksum_q <= checksum_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    end_d      = end_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    checksum_d = checksum_q;
    error_d    = 1'b0;
    rd_en_o    = 1'b0;
    rd_addr_o  = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (first_addr_i <= last_addr_i) begin
            cur_d      = first_addr_i;
            end_d      = last_addr_i;
            checksum_d = '0;
            state_d    = StRead;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StRead: begin
        rd_en_o    = 1'b1;
        rd_addr_o  = cur_q;
        out_addr_d = cur_q;
        out_data_d = rd_data_i;
        checksum_d = checksum_q ^ rd_data_i;
        state_d    = StSend;
      end
      StSend: begin
        if (out_if.ready) begin
          // Terminate on equality before incrementing so last_addr = max never wraps.
          if (cur_q == end_q) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + ADDR_W'(1);
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    out_if.valid = (state_q == StSend);
    out_if.addr  = out_addr_q;
    out_if.data  = out_data_q;
    checksum_o   = checksum_q;
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StDone);
    error_o      = error_q;
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file on the read port.
module tb_regfile_dump_reader;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] checksum;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] regs [32];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) out_if ();

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .first_addr_i (first_addr),
    .last_addr_i  (last_addr),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .out_if       (out_if.master),
    .checksum_o   (checksum),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; out_if.ready = 1'b0;
    tick(); tick();
    checks++;
    if ({rd_en, rd_addr, out_if.valid, out_if.addr, out_if.data, checksum, busy, done, error}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b a=%0d d=%h cs=%h busy=%0b done=%0b err=%0b want all 0",
               out_if.valid, out_if.addr, out_if.data, checksum, busy, done, error);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_dump();
    int beats = 0;
    int done_cyc = -1;
    logic [DW-1:0] exp;
    first_addr = 5'd0; last_addr = 5'd31; out_if.ready = 1'b1; start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    while (done_cyc < 0 && cyc < 200) begin
      if (out_if.valid && out_if.ready) begin
        exp = (beats == 0) ? '0 : 32'h100 + 32'(beats);
        checks++;
        if (out_if.addr !== AW'(beats) || out_if.data !== exp) begin
          errors++;
          $display("FAIL full_beat got (%0d,%h) want (%0d,%h)", out_if.addr, out_if.data,
                   beats, exp);
        end
        beats++;
      end
      if (done) done_cyc = cyc;
      else tick();
    end
    checks++;
    if (done_cyc !== 65) begin
      errors++; $display("FAIL full_done_cycle got %0d want 65", done_cyc);
    end
    checks++;
    if (beats !== 32) begin
      errors++; $display("FAIL full_beat_count got %0d want 32", beats);
    end
    checks++;
    if (checksum !== 32'h0000_0100) begin
      errors++; $display("FAIL full_checksum got %h want 00000100", checksum);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || checksum !== 32'h0000_0100) begin
      errors++; $display("FAIL full_after got busy=%0b cs=%h want busy=0 cs=00000100", busy,
                         checksum);
    end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    int dones = 0;
    int wait_n = 0;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic [DW-1:0] hc;
    first_addr = 5'd3; last_addr = 5'd5; out_if.ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) begin
      if (done) dones++;
      if (out_if.valid) begin
        if (wait_n == 0) begin
          checks++;
          if (out_if.addr !== AW'(3 + beats) || out_if.data !== 32'h103 + 32'(beats)) begin
            errors++;
            $display("FAIL bp_beat got (%0d,%h) want (%0d,%h)", out_if.addr, out_if.data,
                     3 + beats, 32'h103 + 32'(beats));
          end
          ha = out_if.addr; hd = out_if.data; hc = checksum;
        end else begin
          checks++;
          if (out_if.addr !== ha || out_if.data !== hd || checksum !== hc) begin
            errors++;
            $display("FAIL bp_stable got (%0d,%h,%h) want (%0d,%h,%h)", out_if.addr,
                     out_if.data, checksum, ha, hd, hc);
          end
        end
        if (wait_n == 4) begin
          out_if.ready = 1'b1; wait_n = 0; beats++;
        end else begin
          out_if.ready = 1'b0; wait_n++;
        end
      end else begin
        out_if.ready = 1'b0;
      end
      tick();
    end
    checks++;
    if (beats !== 3 || dones !== 1) begin
      errors++; $display("FAIL bp_counts got beats=%0d dones=%0d want 3 and 1", beats, dones);
    end
    checks++;
    if (checksum !== 32'h0000_0102) begin
      errors++; $display("FAIL bp_checksum got %h want 00000102", checksum);
    end
  endtask

  task automatic test_single();
    int beats = 0;
    int done_cyc = -1;
    regs[31] = 32'hDEAD_BEEF;
    first_addr = 5'd31; last_addr = 5'd31; out_if.ready = 1'b1; start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    while (done_cyc < 0 && cyc < 20) begin
      if (out_if.valid) begin
        beats++;
        checks++;
        if (out_if.addr !== 5'd31 || out_if.data !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL single_beat got (%0d,%h) want (31,deadbeef)", out_if.addr, out_if.data);
        end
      end
      if (done) done_cyc = cyc;
      else tick();
    end
    checks++;
    if (done_cyc !== 3 || beats !== 1) begin
      errors++; $display("FAIL single_done got cyc=%0d beats=%0d want 3 and 1", done_cyc, beats);
    end
    checks++;
    if (checksum !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_checksum got %h want deadbeef", checksum);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_if.valid !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL single_nowrap got busy=%0b valid=%0b rd_en=%0b want 0", busy, out_if.valid,
               rd_en);
    end
  endtask

  task automatic test_bad_range();
    first_addr = 5'd10; last_addr = 5'd2; out_if.ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_error got err=%0b busy=%0b want 1 and 0", error, busy);
    end
    tick();
    checks++;
    if (error !== 1'b0 || busy !== 1'b0 || out_if.valid !== 1'b0 || checksum !== 32'hDEAD_BEEF)
    begin
      errors++;
      $display("FAIL bad_after got err=%0b busy=%0b valid=%0b cs=%h want 0,0,0,deadbeef", error,
               busy, out_if.valid, checksum);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    int done_cyc = -1;
    regs[31] = 32'h0000_011F;
    first_addr = 5'd0; last_addr = 5'd31; out_if.ready = 1'b1; start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    while (beats < 3 && cyc < 100) begin
      if (out_if.valid && out_if.ready) beats++;
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({rd_en, rd_addr, out_if.valid, out_if.addr, out_if.data, checksum, busy, done, error}
        !== '0 || beats !== 3) begin
      errors++;
      $display("FAIL mid_reset got beats=%0d v=%0b a=%0d d=%h cs=%h busy=%0b done=%0b want 3/0",
               beats, out_if.valid, out_if.addr, out_if.data, checksum, busy, done);
    end
    rst = 1'b0;
    first_addr = 5'd1; last_addr = 5'd2; start = 1'b1; cyc = 0; beats = 0;
    tick();
    start = 1'b0;
    while (done_cyc < 0 && cyc < 30) begin
      if (out_if.valid) begin
        checks++;
        if (out_if.addr !== AW'(1 + beats) || out_if.data !== 32'h101 + 32'(beats)) begin
          errors++;
          $display("FAIL mid_restart_beat got (%0d,%h) want (%0d,%h)", out_if.addr, out_if.data,
                   1 + beats, 32'h101 + 32'(beats));
        end
        beats++;
      end
      if (done) done_cyc = cyc;
      else tick();
    end
    checks++;
    if (done_cyc !== 5 || checksum !== 32'h0000_0003) begin
      errors++;
      $display("FAIL mid_restart_done got cyc=%0d cs=%h want 5 and 00000003", done_cyc, checksum);
    end
    tick();
  endtask

  task automatic test_start_held();
    int beats = 0;
    int done_cyc = -1;
    first_addr = 5'd4; last_addr = 5'd5; out_if.ready = 1'b1; start = 1'b1; cyc = 0;
    tick();
    while (done_cyc < 0 && cyc < 30) begin
      if (out_if.valid) begin
        checks++;
        if (out_if.addr !== AW'(4 + beats)) begin
          errors++;
          $display("FAIL held_beat got addr %0d want %0d", out_if.addr, 4 + beats);
        end
        beats++;
      end
      if (done) done_cyc = cyc;
      else tick();
    end
    checks++;
    if (done_cyc !== 5 || beats !== 2) begin
      errors++; $display("FAIL held_done got cyc=%0d beats=%0d want 5 and 2", done_cyc, beats);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL held_idle got busy=%0b want 0", busy);
    end
    tick();
    start = 1'b0;
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 5'd4) begin
      errors++; $display("FAIL held_restart got rd_en=%0b rd_addr=%0d want 1 and 4", rd_en, rd_addr);
    end
    done_cyc = -1;
    while (done_cyc < 0 && cyc < 40) begin
      if (done) done_cyc = cyc;
      else tick();
    end
    checks++;
    if (done_cyc !== 11) begin
      errors++; $display("FAIL held_second_done got cyc=%0d want 11", done_cyc);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : 32'h100 + 32'(i);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_single();
    test_bad_range();
    test_reset_mid();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
